// File: rtl/wb_demux_3.sv
// wb_demux_3 - registered 1-to-3 result router for the Mini_MIPS write-back path.
//
// One DW-bit result plus a 2-bit destination code arrives over a valid/ready
// handshake. The result is forwarded to one of three channels, and each channel
// has its own one-entry holding slot:
//   A = register file, B = HI/LO, C = store buffer.
// A stalled channel back-pressures only results addressed to it. Destination
// code 3 is illegal. Such a result is always consumed and then dropped, and the
// drop is flagged on err_pulse and err_sticky.
//
// Optional build macro: WB_DEMUX_STATS_EN. When defined, the router adds
// per-channel transfer counters, a drop counter and a synchronous clear input.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_data  [DW-1:0]        result value
//   in_sel   [1:0]           destination: 0=A, 1=B, 2=C, 3=illegal
//   a/b/c_valid              the channel slot holds a result (registered)
//   a/b/c_ready              the destination consumes this cycle
//   a/b/c_data [DW-1:0]      channel payload (registered)
//   err_pulse                one-cycle pulse after an illegal-sel transfer
//   err_sticky               set by any illegal-sel transfer, cleared by reset
//   cnt_a/b/c, cnt_drop      [CW-1:0] transfer counters (WB_DEMUX_STATS_EN only)
//   stats_clr                synchronous counter clear (WB_DEMUX_STATS_EN only)
module wb_demux_3 #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_sel,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [DW-1:0] a_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [DW-1:0] b_data,
  output logic          c_valid,
  input  logic          c_ready,
  output logic [DW-1:0] c_data,
  output logic          err_pulse,
  output logic          err_sticky
`ifdef WB_DEMUX_STATS_EN
  ,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic [CW-1:0] cnt_c,
  output logic [CW-1:0] cnt_drop,
  input  logic          stats_clr
`endif
);

  if (CW < 1 || DW < 1) begin : g_bad_width
    $error("wb_demux_3: DW and CW must be at least 1");
  end

  logic          r_a_vld_p0, r_b_vld_p0, r_c_vld_p0;
  logic [DW-1:0] r_a_data_p0, r_b_data_p0, r_c_data_p0;
  logic          r_err_pulse_p0, r_err_sticky_p0;

  logic w_free_a, w_free_b, w_free_c;
  logic w_in_ready;
  logic w_xfer;
  logic w_acc_a, w_acc_b, w_acc_c, w_drop;

  // Input stage: a slot is free when empty, or when its drain this cycle
  // makes room for a refill on the same edge.
  assign w_free_a = !r_a_vld_p0 || a_ready;
  assign w_free_b = !r_b_vld_p0 || b_ready;
  assign w_free_c = !r_c_vld_p0 || c_ready;

  always_comb begin
    w_in_ready = 1'b1;
    case (in_sel)
      2'd0:    w_in_ready = w_free_a;
      2'd1:    w_in_ready = w_free_b;
      2'd2:    w_in_ready = w_free_c;
      default: w_in_ready = 1'b1;
    endcase
  end

  assign in_ready = w_in_ready;
  assign w_xfer   = in_valid && w_in_ready;
  assign w_acc_a  = w_xfer && (in_sel == 2'd0);
  assign w_acc_b  = w_xfer && (in_sel == 2'd1);
  assign w_acc_c  = w_xfer && (in_sel == 2'd2);
  assign w_drop   = w_xfer && (in_sel == 2'd3);

  // Channel slot stage: a refill takes priority over a drain, so a slot that
  // drains and refills on the same edge stays valid with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_vld_p0  <= 1'b0;
      r_a_data_p0 <= '0;
    end else if (w_acc_a) begin
      r_a_vld_p0  <= 1'b1;
      r_a_data_p0 <= in_data;
    end else if (r_a_vld_p0 && a_ready) begin
      r_a_vld_p0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_vld_p0  <= 1'b0;
      r_b_data_p0 <= '0;
    end else if (w_acc_b) begin
      r_b_vld_p0  <= 1'b1;
      r_b_data_p0 <= in_data;
    end else if (r_b_vld_p0 && b_ready) begin
      r_b_vld_p0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_vld_p0  <= 1'b0;
      r_c_data_p0 <= '0;
    end else if (w_acc_c) begin
      r_c_vld_p0  <= 1'b1;
      r_c_data_p0 <= in_data;
    end else if (r_c_vld_p0 && c_ready) begin
      r_c_vld_p0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse_p0  <= 1'b0;
      r_err_sticky_p0 <= 1'b0;
    end else begin
      r_err_pulse_p0  <= w_drop;
      r_err_sticky_p0 <= r_err_sticky_p0 || w_drop;
    end
  end

  assign a_valid    = r_a_vld_p0;
  assign a_data     = r_a_data_p0;
  assign b_valid    = r_b_vld_p0;
  assign b_data     = r_b_data_p0;
  assign c_valid    = r_c_vld_p0;
  assign c_data     = r_c_data_p0;
  assign err_pulse  = r_err_pulse_p0;
  assign err_sticky = r_err_sticky_p0;

`ifdef WB_DEMUX_STATS_EN
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt_a, r_cnt_b, r_cnt_c, r_cnt_drop;

  // Statistics stage: the clear wins over a same-cycle increment, and the
  // counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_cnt_c    <= '0;
      r_cnt_drop <= '0;
    end else if (stats_clr) begin
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_cnt_c    <= '0;
      r_cnt_drop <= '0;
    end else begin
      if (w_acc_a) r_cnt_a    <= r_cnt_a + CNT_ONE;
      if (w_acc_b) r_cnt_b    <= r_cnt_b + CNT_ONE;
      if (w_acc_c) r_cnt_c    <= r_cnt_c + CNT_ONE;
      if (w_drop)  r_cnt_drop <= r_cnt_drop + CNT_ONE;
    end
  end

  assign cnt_a    = r_cnt_a;
  assign cnt_b    = r_cnt_b;
  assign cnt_c    = r_cnt_c;
  assign cnt_drop = r_cnt_drop;
`endif

endmodule

// File: tb/tb_wb_demux_3.sv
module tb_wb_demux_3;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          a_valid, b_valid, c_valid;
  logic          a_ready, b_ready, c_ready;
  logic [DW-1:0] a_data, b_data, c_data;
  logic          err_pulse, err_sticky;
`ifdef WB_DEMUX_STATS_EN
  logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_drop;
  logic          stats_clr;
`endif

  int n_vec;
  int n_err;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] q_c[$];
  logic [DW-1:0] exp_d;

  wb_demux_3 #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .c_valid   (c_valid),
    .c_ready   (c_ready),
    .c_data    (c_data),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky)
`ifdef WB_DEMUX_STATS_EN
    ,
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_drop  (cnt_drop),
    .stats_clr (stats_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units after it, once the combinational in_ready has settled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
`ifdef WB_DEMUX_STATS_EN
    stats_clr = 1'b0;
`endif
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    n_vec++; if ({a_valid, b_valid, c_valid} !== 3'b000) begin n_err++; $display("FAIL reset_valid: got %b want 000", {a_valid, b_valid, c_valid}); end
    n_vec++; if ({err_pulse, err_sticky} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b want 00", {err_pulse, err_sticky}); end
    n_vec++; if (a_data !== 32'h0 || b_data !== 32'h0 || c_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h %h %h want 0", a_data, b_data, c_data); end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, in_ready); end
    end
  endtask

  task automatic test_single_a();
    cyc();
    a_ready = 1'b1; in_sel = 2'd0; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    q_a.push_back(in_data);
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if ({a_valid, b_valid, c_valid} !== 3'b100) begin n_err++; $display("FAIL single_valids: got %b want 100", {a_valid, b_valid, c_valid}); end
    n_vec++;
    if (q_a.size() == 0) begin n_err++; $display("FAIL single_a_sb: scoreboard empty, got %h", a_data); end
    else begin exp_d = q_a.pop_front(); if (a_data !== exp_d) begin n_err++; $display("FAIL single_a_data: got %h want %h", a_data, exp_d); end end
    cyc();
    #1;
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL single_a_drain: got %b want 0", a_valid); end
    a_ready = 1'b0;
  endtask

  task automatic test_stall_b();
    cyc();
    b_ready = 1'b0; c_ready = 1'b0;
    in_sel = 2'd1; in_data = 32'h11111111; in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_fill_b: in_ready got %b want 1", in_ready); end
    q_b.push_back(in_data);
    cyc();
    in_data = 32'h22222222;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_block_b: in_ready got %b want 0", in_ready); end
    n_vec++; if (b_valid !== 1'b1 || b_data !== q_b[0]) begin n_err++; $display("FAIL stall_hold_b: got %b/%h want 1/%h", b_valid, b_data, q_b[0]); end
    cyc();
    #1;
    n_vec++; if (b_data !== q_b[0]) begin n_err++; $display("FAIL stall_hold_b2: got %h want %h", b_data, q_b[0]); end
    in_sel = 2'd2; in_data = 32'h33333333;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_pass_c: in_ready got %b want 1", in_ready); end
    q_c.push_back(in_data);
    cyc();
    in_sel = 2'd1; in_data = 32'h22222222; b_ready = 1'b1; c_ready = 1'b1;
    #1;
    n_vec++; if (c_valid !== 1'b1 || b_valid !== 1'b1) begin n_err++; $display("FAIL stall_c_valid: got c=%b b=%b want 1 1", c_valid, b_valid); end
    n_vec++;
    if (q_c.size() == 0) begin n_err++; $display("FAIL stall_c_sb: scoreboard empty, got %h", c_data); end
    else begin exp_d = q_c.pop_front(); if (c_data !== exp_d) begin n_err++; $display("FAIL stall_c_data: got %h want %h", c_data, exp_d); end end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_refill_ready: got %b want 1", in_ready); end
    n_vec++;
    if (q_b.size() == 0) begin n_err++; $display("FAIL stall_b_sb: scoreboard empty, got %h", b_data); end
    else begin exp_d = q_b.pop_front(); if (b_data !== exp_d) begin n_err++; $display("FAIL stall_b_old: got %h want %h", b_data, exp_d); end end
    q_b.push_back(in_data);
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if (b_valid !== 1'b1) begin n_err++; $display("FAIL stall_no_bubble: b_valid got %b want 1", b_valid); end
    n_vec++;
    if (q_b.size() == 0) begin n_err++; $display("FAIL stall_b_sb2: scoreboard empty, got %h", b_data); end
    else begin exp_d = q_b.pop_front(); if (b_data !== exp_d) begin n_err++; $display("FAIL stall_b_new: got %h want %h", b_data, exp_d); end end
    n_vec++; if (c_valid !== 1'b0) begin n_err++; $display("FAIL stall_c_drain: got %b want 0", c_valid); end
    cyc();
    #1;
    n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL stall_b_drain: got %b want 0", b_valid); end
    b_ready = 1'b0; c_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    cyc();
    a_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_sel = 2'd0; in_data = DW'(i); in_valid = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      if (i > 1) begin
        n_vec++;
        if (a_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, a_valid); end
        else if (q_a.size() == 0) begin n_err++; $display("FAIL stream_sb[%0d]: scoreboard empty, got %h", i, a_data); end
        else begin exp_d = q_a.pop_front(); if (a_data !== exp_d) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_data, exp_d); end end
      end
      q_a.push_back(in_data);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (a_valid !== 1'b1 || q_a.size() == 0) begin n_err++; $display("FAIL stream_last: valid got %b want 1, queued %0d", a_valid, q_a.size()); end
    else begin exp_d = q_a.pop_front(); if (a_data !== exp_d) begin n_err++; $display("FAIL stream_last_data: got %h want %h", a_data, exp_d); end end
    cyc();
    #1;
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", a_valid); end
    a_ready = 1'b0;
  endtask

  task automatic test_illegal();
    cyc();
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    in_sel = 2'd3; in_data = 32'hCAFEF00D; in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_ready: got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if ({err_pulse, err_sticky} !== 2'b11) begin n_err++; $display("FAIL illegal_err: got %b want 11", {err_pulse, err_sticky}); end
    n_vec++; if ({a_valid, b_valid, c_valid} !== 3'b000) begin n_err++; $display("FAIL illegal_valids: got %b want 000", {a_valid, b_valid, c_valid}); end
    cyc();
    #1;
    n_vec++; if ({err_pulse, err_sticky} !== 2'b01) begin n_err++; $display("FAIL illegal_pulse_end: got %b want 01", {err_pulse, err_sticky}); end
    in_valid = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL illegal_b2b: err_pulse got %b want 1", err_pulse); end
    cyc();
    #1;
    n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL illegal_b2b_end: err_pulse got %b want 0", err_pulse); end
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    cyc();
    a_ready = 1'b0; in_sel = 2'd0; in_data = 32'h5; in_valid = 1'b1;
    q_a.push_back(in_data);
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if (a_valid !== 1'b1 || a_data !== q_a[0]) begin n_err++; $display("FAIL areset_pre: got %b/%h want 1/%h", a_valid, a_data, q_a[0]); end
    #2;
    rst_n = 1'b0;
    q_a.delete(); q_b.delete(); q_c.delete();
    #1;
    n_vec++; if (a_valid !== 1'b0 || a_data !== 32'h0) begin n_err++; $display("FAIL areset_async: got %b/%h want 0/0", a_valid, a_data); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL areset_sticky: got %b want 0", err_sticky); end
    #1;
    rst_n = 1'b1;
  endtask

`ifdef WB_DEMUX_STATS_EN
  task automatic test_stats();
    cyc();
    n_vec++; if ({cnt_a, cnt_b, cnt_c, cnt_drop} !== '0) begin n_err++; $display("FAIL stats_reset: got %h %h %h %h want 0", cnt_a, cnt_b, cnt_c, cnt_drop); end
    c_ready = 1'b1; in_sel = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(32'h100 + i);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (cnt_c !== CW'(3)) begin n_err++; $display("FAIL stats_cnt_c: got %0d want 3", cnt_c); end
    stats_clr = 1'b1; in_valid = 1'b1;
    cyc();
    stats_clr = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (cnt_c !== CW'(0)) begin n_err++; $display("FAIL stats_clr: got %0d want 0", cnt_c); end
    c_ready = 1'b0;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_a();
    test_stall_b();
    test_back_to_back();
    test_illegal();
    test_async_reset();
`ifdef WB_DEMUX_STATS_EN
    test_stats();
`endif
    cyc();
    n_vec++; if (q_a.size() + q_b.size() + q_c.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", q_a.size() + q_b.size() + q_c.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
